// File: rtl/audio_voice_scheduler.sv
// audio_voice_scheduler
//   Paces stereo frames at SAMPLING_RATE from clk, polls the unmuted voices in
//   index order over a shared return bus, mixes their samples and writes one
//   {L, R} word per frame into the audio FIFO write side.
//   Optional macro: MIX_AVERAGE_EN -- output the arithmetic-shift average of the
//   voices instead of the saturated sum.
module audio_voice_scheduler #(
  parameter int unsigned AUDIO_WIDTH   = 16,
  parameter int unsigned NUM_VOICES    = 4,
  parameter int unsigned CLK_FREQ      = 100000000,
  parameter int unsigned SAMPLING_RATE = 44100,
  parameter int unsigned TIMEOUT       = 15
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            enable,
  input  logic [NUM_VOICES-1:0]           mute_mask,
  output logic [NUM_VOICES-1:0]           voice_req,
  output logic [$clog2(NUM_VOICES)-1:0]   voice_sel,
  input  logic [2*AUDIO_WIDTH-1:0]        voice_data,
  input  logic                            voice_valid,
  output logic [2*AUDIO_WIDTH-1:0]        sample_data,
  output logic                            sample_en,
  input  logic                            sample_full,
  output logic                            overrun,
  output logic                            timeout_err,
  output logic                            busy
);

  localparam int unsigned SEL_W = $clog2(NUM_VOICES);
  localparam int unsigned ACC_W = AUDIO_WIDTH + SEL_W;
  localparam int unsigned PH_W  = $clog2(CLK_FREQ) + 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, WRITE} state_t;

  state_t                   state, state_nx;
  logic [PH_W-1:0]          phase;
  logic [PH_W:0]            phase_sum;
  logic                     tick;
  logic [SEL_W-1:0]         cur, cur_nx;
  logic signed [ACC_W-1:0]  acc_l, acc_r, acc_l_nx, acc_r_nx;
  logic signed [ACC_W-1:0]  ext_l, ext_r;
  logic [CNT_W-1:0]         cnt, cnt_nx;
  logic                     valid_q;
  logic [2*AUDIO_WIDTH-1:0] data_q;
  int unsigned              start_i;
  logic                     nxt_found;
  logic [SEL_W-1:0]         nxt_idx;

  // Per-channel output stage: saturated sum, or average when MIX_AVERAGE_EN.
  function automatic logic [AUDIO_WIDTH-1:0] mix_out(input logic signed [ACC_W-1:0] a);
`ifdef MIX_AVERAGE_EN
    logic signed [ACC_W-1:0] sh;
    sh = a >>> SEL_W;
    return sh[AUDIO_WIDTH-1:0];
`else
    logic [SEL_W:0] top;
    top = a[ACC_W-1:AUDIO_WIDTH-1];
    if (top == '0 || top == '1) return a[AUDIO_WIDTH-1:0];
    else if (a[ACC_W-1])        return {1'b1, {(AUDIO_WIDTH-1){1'b0}}};
    else                        return {1'b0, {(AUDIO_WIDTH-1){1'b1}}};
`endif
  endfunction

  assign phase_sum = {1'b0, phase} + (PH_W+1)'(SAMPLING_RATE);
  assign tick      = enable && (phase_sum >= (PH_W+1)'(CLK_FREQ));
  assign ext_l     = {{SEL_W{data_q[2*AUDIO_WIDTH-1]}}, data_q[2*AUDIO_WIDTH-1:AUDIO_WIDTH]};
  assign ext_r     = {{SEL_W{data_q[AUDIO_WIDTH-1]}}, data_q[AUDIO_WIDTH-1:0]};
  assign overrun   = tick && (state != IDLE);
  assign busy      = (state != IDLE);

  // Phase accumulator: exact long-term frame rate, held at zero while disabled.
  always_ff @(posedge clk) begin
    if (!resetn || !enable) phase <= '0;
    else if (tick)          phase <= PH_W'(phase_sum - (PH_W+1)'(CLK_FREQ));
    else                    phase <= PH_W'(phase_sum);
  end

  // Lowest unmuted voice at or above the search start (0 from IDLE, cur+1 from WAIT).
  always_comb begin
    start_i   = (state == WAIT) ? 32'(cur) + 32'd1 : 32'd0;
    nxt_found = 1'b0;
    nxt_idx   = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (!nxt_found && i >= start_i && !mute_mask[i]) begin
        nxt_found = 1'b1;
        nxt_idx   = SEL_W'(i);
      end
    end
  end

  // Next-state, datapath update and strobe outputs.
  always_comb begin
    state_nx    = state;
    cur_nx      = cur;
    acc_l_nx    = acc_l;
    acc_r_nx    = acc_r;
    cnt_nx      = cnt;
    voice_req   = '0;
    voice_sel   = '0;
    sample_en   = 1'b0;
    timeout_err = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          acc_l_nx = '0;
          acc_r_nx = '0;
          if (nxt_found) begin
            cur_nx   = nxt_idx;
            state_nx = REQ;
          end else begin
            state_nx = OUT;
          end
        end
      end
      REQ: begin
        voice_req[cur] = 1'b1;
        voice_sel      = cur;
        cnt_nx         = '0;
        state_nx       = WAIT;
      end
      WAIT: begin
        voice_sel = cur;
        if (valid_q || cnt == CNT_W'(TIMEOUT)) begin
          if (valid_q) begin
            acc_l_nx = acc_l + ext_l;
            acc_r_nx = acc_r + ext_r;
          end else begin
            timeout_err = 1'b1;
          end
          if (nxt_found) begin
            cur_nx   = nxt_idx;
            state_nx = REQ;
          end else begin
            state_nx = OUT;
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      OUT: begin
        if (!sample_full) state_nx = WRITE;
      end
      WRITE: begin
        sample_en = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and datapath registers. The voice return is registered before use,
  // so a voice answering the cycle after its request is consumed on the second
  // WAIT cycle, giving three cycles per voice.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      cur         <= '0;
      acc_l       <= '0;
      acc_r       <= '0;
      cnt         <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      sample_data <= '0;
    end else begin
      state   <= state_nx;
      cur     <= cur_nx;
      acc_l   <= acc_l_nx;
      acc_r   <= acc_r_nx;
      cnt     <= cnt_nx;
      valid_q <= (state == WAIT) && voice_valid;
      data_q  <= voice_data;
      if (state_nx == OUT && state != OUT)
        sample_data <= {mix_out(acc_l_nx), mix_out(acc_r_nx)};
    end
  end

endmodule

// File: tb/tb_audio_voice_scheduler.sv
// Bench for audio_voice_scheduler: a 2-voice instance for frame pacing and a
// 4-voice instance driven from a table of mixing vectors, plus hand-written
// backpressure, timeout and mid-frame reset sequences.
module tb_audio_voice_scheduler;

`ifdef MIX_AVERAGE_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;

  // 2-voice instance: 1000 Hz clock, 100 Hz frames
  logic        enable_a, vvalid_a, sen_a, sfull_a, ov_a, to_a, busy_a;
  logic [1:0]  mute_a, req_a;
  logic [0:0]  sel_a;
  logic [31:0] vdata_a, sdata_a;

  // 4-voice instance: 1000 Hz clock, 20 Hz frames
  logic        enable_b, vvalid_b, sen_b, sfull_b, ov_b, to_b, busy_b;
  logic [3:0]  mute_b, req_b;
  logic [1:0]  sel_b;
  logic [31:0] vdata_b, sdata_b;

  audio_voice_scheduler #(.AUDIO_WIDTH(16), .NUM_VOICES(2), .CLK_FREQ(1000),
                          .SAMPLING_RATE(100), .TIMEOUT(15)) dut_a (
    .clk(clk), .resetn(resetn), .enable(enable_a), .mute_mask(mute_a),
    .voice_req(req_a), .voice_sel(sel_a), .voice_data(vdata_a), .voice_valid(vvalid_a),
    .sample_data(sdata_a), .sample_en(sen_a), .sample_full(sfull_a),
    .overrun(ov_a), .timeout_err(to_a), .busy(busy_a));

  audio_voice_scheduler #(.AUDIO_WIDTH(16), .NUM_VOICES(4), .CLK_FREQ(1000),
                          .SAMPLING_RATE(20), .TIMEOUT(15)) dut_b (
    .clk(clk), .resetn(resetn), .enable(enable_b), .mute_mask(mute_b),
    .voice_req(req_b), .voice_sel(sel_b), .voice_data(vdata_b), .voice_valid(vvalid_b),
    .sample_data(sdata_b), .sample_en(sen_b), .sample_full(sfull_b),
    .overrun(ov_b), .timeout_err(to_b), .busy(busy_b));

  // Voice contents for instance B, set by the main sequence
  logic [15:0] vl [4];
  logic [15:0] vr [4];
  logic [3:0]  resp;

  // Voices answer one cycle after the request cycle
  initial begin
    logic [1:0] pa;
    vvalid_a = 1'b0;
    vdata_a  = '0;
    forever begin
      @(negedge clk);
      pa = req_a;
      @(posedge clk);
      #1;
      vvalid_a = |pa;
      vdata_a  = 32'h0001_0002;
    end
  end

  initial begin
    logic [3:0] pb;
    int idx;
    vvalid_b = 1'b0;
    vdata_b  = '0;
    forever begin
      @(negedge clk);
      pb = req_b;
      @(posedge clk);
      #1;
      idx = 0;
      for (int i = 0; i < 4; i++) if (pb[i]) idx = i;
      vvalid_b = (pb != 4'b0) && resp[idx];
      vdata_b  = {vl[idx], vr[idx]};
    end
  end

  // Event monitor, sampled on the falling edge
  int cyc = 0;
  int en_t_a [64];
  int en_n_a = 0, ov_n_a = 0, to_n_a = 0;
  int req_cnt_v [4] = '{0, 0, 0, 0};
  int req1_cyc = 0, to_cyc_b = 0;
  int ov_n_b = 0, to_n_b = 0, en_n_b = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (sen_a) begin
      if (en_n_a < 64) en_t_a[en_n_a] <= cyc;
      en_n_a <= en_n_a + 1;
    end
    if (ov_a) ov_n_a <= ov_n_a + 1;
    if (to_a) to_n_a <= to_n_a + 1;
    for (int i = 0; i < 4; i++) if (req_b[i]) req_cnt_v[i] <= req_cnt_v[i] + 1;
    if (req_b[1]) req1_cyc <= cyc;
    if (to_b) begin
      to_n_b   <= to_n_b + 1;
      to_cyc_b <= cyc;
    end
    if (ov_b)  ov_n_b <= ov_n_b + 1;
    if (sen_b) en_n_b <= en_n_b + 1;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  mute;
    logic [3:0]  resp;
    logic [63:0] l;      // voice i at [16*i +: 16]
    logic [63:0] r;
    logic [31:0] exp;
    int          n_req;
    logic [3:0]  visit;
    int          n_to;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] mute, input logic [3:0] rs,
                              input logic [63:0] l, input logic [63:0] r,
                              input logic [31:0] e_sat, input logic [31:0] e_avg,
                              input int n_req, input logic [3:0] visit, input int n_to);
    vec_t v;
    v.mute = mute; v.resp = rs; v.l = l; v.r = r;
    v.exp = AVG ? e_avg : e_sat;
    v.n_req = n_req; v.visit = visit; v.n_to = n_to;
    return v;
  endfunction

  task automatic load(input vec_t v);
    mute_b = v.mute;
    resp   = v.resp;
    for (int i = 0; i < 4; i++) begin
      vl[i] = v.l[16*i +: 16];
      vr[i] = v.r[16*i +: 16];
    end
  endtask

  vec_t tv [7];

  initial begin
    int rs [4];
    int e0, o0, t0, k, nreq;
    logic [3:0] vis;

    tv[0] = mk(4'b0000, 4'b1111, {4{16'h7000}}, {4{16'h9000}},
               32'h7FFF_8000, 32'h7000_9000, 4, 4'b1111, 0);
    tv[1] = mk(4'b0000, 4'b1111, {16'hFFF6, 16'h0003, 16'h0002, 16'h0001}, 64'h0,
               32'hFFFC_0000, 32'hFFFF_0000, 4, 4'b1111, 0);
    tv[2] = mk(4'b1010, 4'b1111, {16'h1111, 16'h0007, 16'h2222, 16'h0005},
               {16'h3333, 16'hFFFE, 16'h4444, 16'hFFFF},
               32'h000C_FFFD, 32'h0003_FFFF, 2, 4'b0101, 0);
    tv[3] = mk(4'b1111, 4'b1111, {4{16'h1234}}, {4{16'h4321}},
               32'h0000_0000, 32'h0000_0000, 0, 4'b0000, 0);
    tv[4] = mk(4'b0000, 4'b1101, {16'h012C, 16'h00C8, 16'h1234, 16'h0064},
               {16'h0001, 16'hFFFF, 16'h1234, 16'hFF9C},
               32'h0258_FF9C, 32'h0096_FFE7, 4, 4'b1111, 1);
    tv[5] = mk(4'b0000, 4'b1111, {4{16'h8000}}, {4{16'h7FFF}},
               32'h8000_7FFF, 32'h8000_7FFF, 4, 4'b1111, 0);
    tv[6] = mk(4'b0110, 4'b1111, {16'h0001, 16'hAAAA, 16'hBBBB, 16'h7FFF},
               {16'hFFFF, 16'hCCCC, 16'hDDDD, 16'h8000},
               32'h7FFF_8000, 32'h2000_DFFF, 2, 4'b1001, 0);

    resetn = 1'b0;
    enable_a = 1'b0; mute_a = '0; sfull_a = 1'b0;
    enable_b = 1'b0; mute_b = '0; sfull_b = 1'b0;
    load(tv[0]);
    repeat (3) step();
    chk("reset_a", {req_a, sel_a, sdata_a, sen_a, ov_a, to_a, busy_a}, 64'h0);
    chk("reset_b", {req_b, sel_b, sdata_b, sen_b, ov_b, to_b, busy_b}, 64'h0);
    resetn = 1'b1;
    step();

    // Frame pacing: 50 intervals of exactly 10 cycles, no overrun
    enable_a = 1'b1;
    for (k = 0; k < 800 && en_n_a < 51; k++) step();
    enable_a = 1'b0;
    chk("rate_frames", en_n_a >= 51, 1);
    for (int i = 1; i < 51; i++) chk("rate_interval", en_t_a[i] - en_t_a[i-1], 10);
    chk("rate_overrun", ov_n_a, 0);
    chk("rate_timeout", to_n_a, 0);
    chk("rate_data", sdata_a, AVG ? 32'h0001_0002 : 32'h0002_0004);

    // Table-driven mixing vectors
    for (int v = 0; v < 7; v++) begin
      load(tv[v]);
      for (int i = 0; i < 4; i++) rs[i] = req_cnt_v[i];
      e0 = en_n_b; o0 = ov_n_b; t0 = to_n_b;
      enable_b = 1'b1;
      for (k = 0; k < 200 && en_n_b == e0; k++) step();
      enable_b = 1'b0;
      repeat (3) step();
      nreq = 0;
      vis  = '0;
      for (int i = 0; i < 4; i++) begin
        nreq   = nreq + (req_cnt_v[i] - rs[i]);
        vis[i] = (req_cnt_v[i] != rs[i]);
      end
      chk($sformatf("v%0d_data", v), sdata_b, tv[v].exp);
      chk($sformatf("v%0d_writes", v), en_n_b - e0, 1);
      chk($sformatf("v%0d_nreq", v), nreq, tv[v].n_req);
      chk($sformatf("v%0d_visit", v), vis, tv[v].visit);
      chk($sformatf("v%0d_timeouts", v), to_n_b - t0, tv[v].n_to);
      chk($sformatf("v%0d_overrun", v), ov_n_b - o0, 0);
      if (tv[v].n_to != 0) chk($sformatf("v%0d_to_latency", v), to_cyc_b - req1_cyc, 16);
    end

    // Backpressure: three ticks while stalled in OUT, then a single write
    load(tv[1]);
    sfull_b = 1'b1;
    e0 = en_n_b; o0 = ov_n_b;
    enable_b = 1'b1;
    for (k = 0; k < 400 && ov_n_b - o0 < 3; k++) step();
    enable_b = 1'b0;
    chk("bp_overruns", ov_n_b - o0, 3);
    chk("bp_no_write", en_n_b - e0, 0);
    chk("bp_busy", busy_b, 1);
    chk("bp_data_held", sdata_b, tv[1].exp);
    repeat (20) step();
    chk("bp_still_stalled", en_n_b - e0, 0);
    sfull_b = 1'b0;
    repeat (4) step();
    chk("bp_one_write", en_n_b - e0, 1);
    chk("bp_data", sdata_b, tv[1].exp);
    chk("bp_idle", busy_b, 0);

    // Reset while waiting on a silent voice 1
    load(tv[4]);
    rs[1] = req_cnt_v[1];
    e0 = en_n_b; t0 = to_n_b;
    enable_b = 1'b1;
    for (k = 0; k < 200 && req_cnt_v[1] == rs[1]; k++) step();
    chk("rst_reached_v1", req_cnt_v[1] - rs[1], 1);
    repeat (5) step();
    chk("rst_busy_before", busy_b, 1);
    resetn   = 1'b0;
    enable_b = 1'b0;
    step();
    chk("rst_outputs", {req_b, sel_b, sdata_b, sen_b, ov_b, to_b, busy_b}, 64'h0);
    resetn = 1'b1;
    repeat (40) step();
    chk("rst_no_write", en_n_b - e0, 0);
    chk("rst_no_timeout", to_n_b - t0, 0);
    chk("rst_idle", busy_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
